// File: rtl/avg_sched_pkg.sv
// Shared types and widths for the averaging scheduler.
package avg_sched_pkg;

    localparam int unsigned SAMPLE_W    = 4;
    localparam int unsigned SUM_W       = 6;
    localparam int unsigned WIN         = 4;
    localparam int unsigned FLUSH_LOADS = 2;

    // Counter widths derived from the window and flush lengths
    localparam int unsigned CNT_W = $clog2(WIN + 1);
    localparam int unsigned FL_W  = $clog2(FLUSH_LOADS + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/avg_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr_i, wrapping.
// Produces both a one-hot grant and the binary index of the winner.
module avg_sched_rr_arbiter #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CHW = $clog2(NCH)
) (
    input  logic [NCH-1:0] req_i,
    input  logic [CHW-1:0] ptr_i,
    output logic [NCH-1:0] gnt_o,
    output logic [CHW-1:0] idx_o,
    output logic           any_o
);

    localparam int unsigned CW1 = CHW + 1;

    logic [CW1-1:0] cand;

    // Scan from the pointer upward; the first hit wins
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cand = CW1'(ptr_i) + CW1'(i);
            if (cand >= CW1'(NCH)) begin
                cand = cand - CW1'(NCH);
            end
            if (!any_o && req_i[cand[CHW-1:0]]) begin
                any_o                 = 1'b1;
                idx_o                 = cand[CHW-1:0];
                gnt_o[cand[CHW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/avg_sched.sv
// Round-robin scheduler sharing one 4-sample moving-average datapath
// between NCH requesters. Each grant runs CLEAR, 4 sample loads,
// 2 zero flush loads, then captures the window sum with the channel tag.
// Optional macro AVG_SCHED_TIMEOUT_EN adds a FEED stall timeout and res_err.
module avg_sched
    import avg_sched_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned CHW = $clog2(NCH)
`ifdef AVG_SCHED_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          req_valid,
    input  logic [SAMPLE_W*NCH-1:0] req_data,
    output logic [NCH-1:0]          req_ready,
    output logic                    avg_rst,
    output logic                    avg_load,
    output logic [SAMPLE_W-1:0]     avg_x,
    input  logic [SUM_W-1:0]        avg_y,
    output logic                    res_valid,
    output logic [CHW-1:0]          res_ch,
    output logic [SUM_W-1:0]        res_data,
`ifdef AVG_SCHED_TIMEOUT_EN
    output logic                    res_err,
`endif
    output logic                    busy
);

`ifdef AVG_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
`endif

    state_e               state_q, state_d;
    logic [CHW-1:0]       ptr_q, ptr_d;
    logic [CHW-1:0]       g_q, g_d;
    logic [NCH-1:0]       g_oh_q, g_oh_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FL_W-1:0]      fl_q, fl_d;
    logic                 res_valid_q, res_valid_d;
    logic [CHW-1:0]       res_ch_q, res_ch_d;
    logic [SUM_W-1:0]     res_data_q, res_data_d;
`ifdef AVG_SCHED_TIMEOUT_EN
    logic [TO_W-1:0]      stall_q, stall_d;
    logic                 res_err_q, res_err_d;
`endif

    logic [NCH-1:0]       arb_gnt;
    logic [CHW-1:0]       arb_idx;
    logic                 arb_any;
    logic                 accept;
    logic [SAMPLE_W-1:0]  samp [NCH];

    avg_sched_rr_arbiter #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_rr_arbiter (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Unpack the flat sample bus into per-channel lanes
    for (genvar k = 0; k < NCH; k++) begin : g_samp
        assign samp[k] = req_data[k*SAMPLE_W +: SAMPLE_W];
    end

    // Handshake and averager-facing combinational outputs
    always_comb begin
        accept    = (state_q == S_FEED) && req_valid[g_q];
        req_ready = (state_q == S_FEED) ? g_oh_q : '0;
        avg_rst   = rst || (state_q == S_CLEAR);
        avg_load  = !rst && (accept || (state_q == S_FLUSH));
        avg_x     = (state_q == S_FEED) ? samp[g_q] : '0;
        busy      = (state_q != S_IDLE);
    end

    // Burst sequencing: arbitrate, clear, feed, flush, capture
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        g_d         = g_q;
        g_oh_d      = g_oh_q;
        cnt_d       = cnt_q;
        fl_d        = fl_q;
        res_valid_d = 1'b0;
        res_ch_d    = res_ch_q;
        res_data_d  = res_data_q;
`ifdef AVG_SCHED_TIMEOUT_EN
        stall_d     = stall_q;
        res_err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    g_d     = arb_idx;
                    g_oh_d  = arb_gnt;
                    ptr_d   = (arb_idx == CHW'(NCH - 1)) ? '0 : arb_idx + CHW'(1);
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
`ifdef AVG_SCHED_TIMEOUT_EN
                stall_d = '0;
`endif
                state_d = S_FEED;
            end
            S_FEED: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef AVG_SCHED_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (cnt_q == CNT_W'(WIN - 1)) begin
                        fl_d    = '0;
                        state_d = S_FLUSH;
                    end
                end
`ifdef AVG_SCHED_TIMEOUT_EN
                else begin
                    stall_d = stall_q + TO_W'(1);
                    // Abandon the burst; the pointer already moved past g
                    if (stall_q == TO_W'(TIMEOUT - 1)) begin
                        stall_d   = '0;
                        res_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
`endif
            end
            S_FLUSH: begin
                fl_d = fl_q + FL_W'(1);
                if (fl_q == FL_W'(FLUSH_LOADS - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                res_valid_d = 1'b1;
                res_ch_d    = g_q;
                res_data_d  = avg_y;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            g_q         <= '0;
            g_oh_q      <= '0;
            cnt_q       <= '0;
            fl_q        <= '0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
`ifdef AVG_SCHED_TIMEOUT_EN
            stall_q     <= '0;
            res_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            g_q         <= g_d;
            g_oh_q      <= g_oh_d;
            cnt_q       <= cnt_d;
            fl_q        <= fl_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_data_q  <= res_data_d;
`ifdef AVG_SCHED_TIMEOUT_EN
            stall_q     <= stall_d;
            res_err_q   <= res_err_d;
`endif
        end
    end

    assign res_valid = res_valid_q;
    assign res_ch    = res_ch_q;
    assign res_data  = res_data_q;
`ifdef AVG_SCHED_TIMEOUT_EN
    assign res_err   = res_err_q;
`endif

endmodule

// File: tb/tb_avg_sched.sv
// Self-checking bench for avg_sched with a behavioural averager model,
// per-channel sample FIFOs and a result scoreboard.
module tb_avg_sched;

    localparam int unsigned NCH   = 4;
    localparam int unsigned CHW   = 2;
    localparam int unsigned DEPTH = 64;

    logic                clk = 1'b0;
    logic                rst;
    logic [NCH-1:0]      req_valid;
    logic [4*NCH-1:0]    req_data;
    logic [NCH-1:0]      req_ready;
    logic                avg_rst;
    logic                avg_load;
    logic [3:0]          avg_x;
    logic [5:0]          avg_y;
    logic                res_valid;
    logic [CHW-1:0]      res_ch;
    logic [5:0]          res_data;
    logic                busy;
`ifdef AVG_SCHED_TIMEOUT_EN
    logic                res_err;
`endif

    avg_sched #(
        .NCH (NCH),
        .CHW (CHW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .avg_rst   (avg_rst),
        .avg_load  (avg_load),
        .avg_x     (avg_x),
        .avg_y     (avg_y),
        .res_valid (res_valid),
        .res_ch    (res_ch),
        .res_data  (res_data),
`ifdef AVG_SCHED_TIMEOUT_EN
        .res_err   (res_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int data;
    } exp_t;

    exp_t        sb [$];
    int          res_cycs [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          load_total = 0;
    int          rst_cyc  = -1;
    int          err_total = 0;
    logic [3:0]  fifo [NCH][DEPTH];
    int          wr [NCH] = '{0, 0, 0, 0};
    int          rd [NCH] = '{0, 0, 0, 0};
    logic [NCH-1:0] acc = '0;
    logic [3:0]  pipe [5];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Sources present the head of each channel FIFO while it is non-empty
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            req_valid[k]       = (rd[k] != wr[k]);
            req_data[k*4 +: 4] = (rd[k] != wr[k]) ? fifo[k][rd[k] % DEPTH] : 4'd0;
        end
    end

    // Averager model: 2-load input delay followed by a 4-sample window sum
    always @(posedge clk) begin
        if (avg_rst) begin
            for (int i = 0; i < 5; i++) pipe[i] <= 4'd0;
            avg_y <= 6'd0;
        end else if (avg_load) begin
            pipe[0] <= avg_x;
            for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
            avg_y <= 6'(pipe[1]) + 6'(pipe[2]) + 6'(pipe[3]) + 6'(pipe[4]);
        end
    end

    // Mid-cycle monitor: handshakes, load count, scoreboard comparison
    always @(negedge clk) begin
        for (int k = 0; k < NCH; k++) acc[k] = req_valid[k] && req_ready[k];
        if (!rst && avg_load) load_total++;
        if (!rst && avg_rst) rst_cyc = cyc;
`ifdef AVG_SCHED_TIMEOUT_EN
        if (res_err) err_total++;
`endif
        if (res_valid) begin
            exp_t e;
            res_cycs.push_back(cyc);
            check("sb_nonempty", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("res_ch", int'(res_ch), e.ch);
                check("res_data", int'(res_data), e.data);
            end
        end
    end

    // Consume accepted samples and advance the cycle counter after each edge
    always @(posedge clk) begin
        #1;
        cyc++;
        for (int k = 0; k < NCH; k++) if (acc[k]) rd[k]++;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input int ch, input int v);
        fifo[ch][wr[ch] % DEPTH] = 4'(v);
        wr[ch]++;
    endtask

    task automatic push4(input int ch, input int a, input int b, input int c, input int d);
        push(ch, a);
        push(ch, b);
        push(ch, c);
        push(ch, d);
    endtask

    task automatic expect_res(input int ch, input int data);
        exp_t e;
        e.ch   = ch;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0 && !busy) break;
            tick(1);
        end
        check(tag, sb.size(), 0);
        check({tag, "_idle"}, int'(busy), 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        int c0;
        int n0;
        int base;

        rst = 1'b1;
        tick(3);
        check("rst_avg_rst", int'(avg_rst), 1);
        check("rst_avg_load", int'(avg_load), 0);
        rst = 1'b0;
        tick(1);
        check("reset_res_valid", int'(res_valid), 0);
        check("reset_res_ch", int'(res_ch), 0);
        check("reset_res_data", int'(res_data), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_req_ready", int'(req_ready), 0);

        // Single channel, no stalls: latency and load count
        base = load_total;
        n0   = res_cycs.size();
        c0   = cyc;
        push4(0, 4, 8, 12, 15);
        expect_res(0, 39);
        tick(12);
        check("t1_res_count", res_cycs.size() - n0, 1);
        if (res_cycs.size() > n0) check("t1_res_cycle", res_cycs[n0] - c0, 9);
        check("t1_loads", load_total - base, 6);
        check("t1_clear_cycle", rst_cyc - c0, 1);
        drain("t1_drain", 20);

        // All channels requesting: strict rotation, 9-cycle spacing
        pulse_reset();
        n0 = res_cycs.size();
        for (int k = 0; k < NCH; k++) begin
            push4(k, k + 1, k + 1, k + 1, k + 1);
            expect_res(k, 4 * (k + 1));
        end
        drain("t2_drain", 60);
        check("t2_res_count", res_cycs.size() - n0, 4);
        if (res_cycs.size() == n0 + 4) begin
            for (int i = 1; i < 4; i++) check("t2_gap", res_cycs[n0+i] - res_cycs[n0+i-1], 9);
        end

        // Granted channel stalls 3 cycles after its 2nd sample
        base = load_total;
        n0   = res_cycs.size();
        c0   = cyc;
        push(2, 1);
        push(2, 2);
        expect_res(2, 10);
        tick(7);
        check("t3_stall_loads", load_total - base, 2);
        check("t3_stall_busy", int'(busy), 1);
        push(2, 3);
        push(2, 4);
        drain("t3_drain", 20);
        check("t3_loads", load_total - base, 6);
        if (res_cycs.size() > n0) check("t3_res_cycle", res_cycs[n0] - c0, 12);

        // Full-scale burst followed by an all-zero burst on the same channel
        push4(1, 15, 15, 15, 15);
        push4(1, 0, 0, 0, 0);
        expect_res(1, 60);
        expect_res(1, 0);
        drain("t4_drain", 40);

        // Reset during FLUSH aborts the burst silently
        push4(3, 7, 7, 7, 7);
        tick(6);
        check("t5_busy_flush", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("t5_rst_avg_load", int'(avg_load), 0);
        check("t5_rst_avg_rst", int'(avg_rst), 1);
        tick(1);
        rst = 1'b0;
        check("t5_busy_after", int'(busy), 0);
        check("t5_res_valid", int'(res_valid), 0);
        n0 = res_cycs.size();
        tick(12);
        check("t5_no_result", res_cycs.size() - n0, 0);
        push4(3, 5, 5, 5, 5);
        expect_res(3, 20);
        drain("t5_drain", 20);

`ifdef AVG_SCHED_TIMEOUT_EN
        // Granted channel goes silent: abort with res_err, rotation continues
        base = err_total;
        n0   = res_cycs.size();
        push(0, 1);
        tick(25);
        check("t6_err", err_total - base, 1);
        check("t6_no_result", res_cycs.size() - n0, 0);
        check("t6_idle", int'(busy), 0);
        push4(0, 1, 1, 1, 1);
        push4(1, 2, 2, 2, 2);
        expect_res(1, 8);
        expect_res(0, 4);
        drain("t6_drain", 40);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
